// File: rtl/key_input_port_if.sv
// Avalon-MM slave register bus for key_input_port: word address, select,
// active-low write strobe and registered read data.
interface key_input_port_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/key_input_port.sv
// Debounced key input port with falling-edge capture, irq mask and Avalon-MM
// register access. Define KEY_INPUT_DEBOUNCE_EN to enable the per-bit debounce filter.
module key_input_port #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DB_COUNT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  key_input_port_if.slave  bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] sync_2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ec_clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= in_port;
      sync_2 <= sync_1;
    end
  end

`ifdef KEY_INPUT_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_COUNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

  logic [CW-1:0] db_cnt [WIDTH];

  // A bit only moves once the synchronized level has disagreed with stable
  // for DB_COUNT consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync_2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          stable[i] <= sync_2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable <= '0;
    else          stable <= sync_2;
  end
`endif

  assign wr_en  = bus.chipselect & ~bus.write_n;
  assign fall   = stable_d & ~stable;
  assign ec_clr = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // Set is OR-ed after the clear so a coincident edge wins over write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d    <= '0;
      edgecapture <= '0;
      irqmask     <= '0;
    end else begin
      stable_d    <= stable;
      edgecapture <= (edgecapture & ~ec_clr) | fall;
      if (wr_en && bus.address == 2'd1) irqmask <= bus.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_mux;
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_key_input_port.sv
// Directed self-checking bench for key_input_port; expectations follow the
// build selected by KEY_INPUT_DEBOUNCE_EN.
module tb_key_input_port;
  localparam int unsigned WIDTH    = 4;
  localparam int unsigned DB_COUNT = 16;
`ifdef KEY_INPUT_DEBOUNCE_EN
  localparam int unsigned CAP_LAT = DB_COUNT + 3;
`else
  localparam int unsigned CAP_LAT = 4;
`endif
  localparam int unsigned SETTLE = CAP_LAT + 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_port;
  logic             irq;
  int unsigned      n_checks = 0;
  int unsigned      n_fail   = 0;
  logic [31:0]      rdat;
  int unsigned      changes;
  logic             prev;

  key_input_port_if bus ();

  key_input_port #(.WIDTH(WIDTH), .DB_COUNT(DB_COUNT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    tick();
    d              = bus.readdata;
    bus.chipselect = 1'b0;
    bus.address    = 2'd0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = '0;
  endtask

  task automatic press(input logic [WIDTH-1:0] pat);
    in_port = pat;
    wait_cycles(SETTLE);
    in_port = 4'hF;
    wait_cycles(SETTLE);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b0;
    in_port        = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    wait_cycles(2);
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;

    // idle-high keys after reset: data settles high, no capture
    wait_cycles(SETTLE);
    rd(2'd0, rdat); check("idle_data", rdat, 32'hF);
    rd(2'd3, rdat); check("idle_edgecap", rdat, 32'h0);
    rd(2'd1, rdat); check("idle_irqmask", rdat, 32'h0);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, rdat); check("reserved_read", rdat, 32'h0);
    wr(2'd0, 32'h0);
    rd(2'd0, rdat); check("data_readonly", rdat, 32'hF);
    check("idle_irq", {31'h0, irq}, 32'h0);

    // bouncing key 0, readdata tracks address 0 every cycle
    prev    = bus.readdata[0];
    changes = 0;
    for (int unsigned c = 0; c < 42 + DB_COUNT + 12; c++) begin
      in_port[0] = (c < 42) ? 1'((c / 3) % 2) : 1'b0;
      tick();
      if (bus.readdata[0] != prev) changes++;
      prev = bus.readdata[0];
    end
`ifdef KEY_INPUT_DEBOUNCE_EN
    check("bounce_changes", changes, 32'd1);
`else
    check("bounce_changes", changes, 32'd15);
`endif
    rd(2'd0, rdat); check("bounce_data", rdat, 32'hE);
    rd(2'd3, rdat); check("bounce_edgecap", rdat, 32'h1);
    wr(2'd3, 32'hF);
    in_port = 4'hF;
    wait_cycles(SETTLE);
    rd(2'd3, rdat); check("release_no_capture", rdat, 32'h0);

    // masked irq and write-1-to-clear
    wr(2'd1, 32'h2);
    rd(2'd1, rdat); check("irqmask_rw", rdat, 32'h2);
    press(4'hD);
    press(4'hE);
    rd(2'd3, rdat); check("two_keys_edgecap", rdat, 32'h3);
    check("masked_irq_set", {31'h0, irq}, 32'h1);
    wr(2'd3, 32'h2);
    check("irq_after_clear", {31'h0, irq}, 32'h0);
    rd(2'd3, rdat); check("partial_clear", rdat, 32'h1);
    wr(2'd1, 32'h1);
    check("irq_on_mask_write", {31'h0, irq}, 32'h1);
    wr(2'd1, 32'h0);
    wr(2'd3, 32'hF);
    rd(2'd3, rdat); check("full_clear", rdat, 32'h0);

    // clear and new edge on bit 2 land on the same clock edge
    in_port = 4'hB;
    wait_cycles(CAP_LAT - 1);
    wr(2'd3, 32'h4);
    rd(2'd3, rdat); check("set_beats_clear", rdat, 32'h4);
    wr(2'd3, 32'h4);
    rd(2'd3, rdat); check("later_clear", rdat, 32'h0);
    in_port = 4'hF;
    wait_cycles(SETTLE);

    // short pulse on key 3
`ifdef KEY_INPUT_DEBOUNCE_EN
    in_port = 4'h7;
    wait_cycles(DB_COUNT - 2);
    in_port = 4'hF;
    wait_cycles(SETTLE);
    rd(2'd3, rdat); check("short_pulse_edgecap", rdat, 32'h0);
`else
    in_port = 4'h7;
    wait_cycles(3);
    in_port = 4'hF;
    wait_cycles(SETTLE);
    rd(2'd3, rdat); check("short_pulse_edgecap", rdat, 32'h8);
`endif
    rd(2'd0, rdat); check("short_pulse_data", rdat, 32'hF);
    wr(2'd3, 32'hF);

    // asynchronous reset with irq high and a count in flight
    wr(2'd1, 32'hF);
    in_port = 4'hD;
    wait_cycles(CAP_LAT + 2);
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    in_port = 4'hC;
    wait_cycles(3);
    reset_n = 1'b0;
    #1;
    check("async_reset_irq", {31'h0, irq}, 32'h0);
    check("async_reset_readdata", bus.readdata, 32'h0);
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(SETTLE);
    rd(2'd3, rdat); check("post_reset_edgecap", rdat, 32'h0);
    rd(2'd1, rdat); check("post_reset_irqmask", rdat, 32'h0);
    rd(2'd0, rdat); check("post_reset_data", rdat, 32'hC);
    check("post_reset_irq", {31'h0, irq}, 32'h0);
    in_port = 4'hF;
    wait_cycles(SETTLE);
    rd(2'd0, rdat); check("final_data", rdat, 32'hF);
    rd(2'd3, rdat); check("final_edgecap", rdat, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_input_port.md
KEY_INPUT_PORT -- requirements
Module: key_input_port

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, number of input bits (1..32).
REQ-002 SHALL provide parameter DB_COUNT, default 16, consecutive stable cycles required to accept a new input level (>=2).
REQ-003 clk  input  1  rising-edge clock for all logic.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select; qualifies reads and writes.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data; bits above WIDTH-1 ignored.
REQ-009 in_port  input  WIDTH  asynchronous external inputs (active-low keys).
REQ-010 readdata  output  32  registered read data, zero-extended above WIDTH-1.
REQ-011 irq  output  1  active-high level interrupt.

Function
REQ-012 SHALL pass each in_port bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL keep one debounced state register "stable" of WIDTH bits; reads of address 0 return stable.
REQ-014 SHALL detect a falling edge on bit i when stable[i] goes 1->0 between consecutive cycles; 0->1 transitions SHALL NOT be captured.
REQ-015 SHALL set edgecapture[i] in the cycle after the falling edge of stable[i]; the bit stays set until cleared by software.
REQ-016 Register map: addr 0 data (RO, writes ignored); addr 1 irqmask (RW, WIDTH bits); addr 2 reserved (reads 0, writes ignored); addr 3 edgecapture (read; write-1-to-clear per bit).
REQ-017 A write SHALL occur when chipselect=1 and write_n=0 on a rising clk edge.
REQ-018 If a clear and a new edge hit the same edgecapture bit in the same cycle, the set SHALL win.
REQ-019 readdata SHALL be registered every cycle from the address mux, giving read latency of exactly 1 cycle; address changes without chipselect still update readdata.
REQ-020 irq SHALL equal OR over i of (edgecapture[i] AND irqmask[i]), driven from registers only.
REQ-021 Writing irqmask with a bit set while the matching edgecapture bit is already set SHALL assert irq in the next cycle.

Reset
REQ-022 On reset_n=0: synchronizer flops, stable, edgecapture, irqmask, readdata and debounce counters SHALL be 0; irq SHALL be 0.
REQ-023 Because stable resets to 0, idle-high inputs after reset SHALL produce a 0->1 transition only and SHALL NOT set edgecapture.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; counting restarts from 0 after release.

Configuration
REQ-025 Macro KEY_INPUT_DEBOUNCE_EN SHALL select the debounce filter.
REQ-026 With KEY_INPUT_DEBOUNCE_EN defined: per-bit counter increments while synchronized bit differs from stable[i]; counter clears whenever they match; when counter reaches DB_COUNT-1, stable[i] takes the synchronized value and counter clears, so a clean step updates stable DB_COUNT cycles after the synchronizer output changes.
REQ-027 Without KEY_INPUT_DEBOUNCE_EN: stable SHALL be the synchronizer output registered once (1-cycle), no counters synthesized, DB_COUNT unused.
REQ-028 Register map, edge capture, irq and read latency SHALL be identical in both builds.

Verification
REQ-029 Reset, in_port=4'hF held: read addr 0 -> 4'hF after sync+debounce settles; read addr 3 -> 0; irq=0.
REQ-030 Debounce on: in_port[0] drops to 0 and bounces 1/0 every 3 cycles for 40 cycles, then held 0 -> stable[0] changes exactly once; edgecapture=4'h1.
REQ-031 irqmask=4'h2, press key 1 then key 0 -> edgecapture=4'h3, irq=1; write addr 3 with 4'h2 -> edgecapture=4'h1, irq=0 next cycle.
REQ-032 Write-clear of bit 2 in the same cycle as a new falling edge on bit 2 -> edgecapture[2] remains 1.
REQ-033 Pulse shorter than DB_COUNT-1 cycles (debounce on) -> no change to data or edgecapture; debounce off -> pulse of >=3 cycles captured.
REQ-034 Assert reset_n during a pending debounce count and with irq=1 -> all registers 0, irq=0 asynchronously; no spurious capture after release.
